// File: rtl/data_mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter and access sequencer for the small data memory.
// Optional address range check is enabled by defining DATA_MEM_ARB_ADDR_CHECK_EN.
module data_mem_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int MEM_AW     = 3,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DMA = 1'b1;

`ifdef DATA_MEM_ARB_ADDR_CHECK_EN
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] a);
        return (a >> MEM_AW) != '0;
    endfunction
`endif

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic                bad_q, bad_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic                cpu_err_q, cpu_err_d, dma_err_q, dma_err_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic                sel_s, sel_we_s, sel_bad_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [DATA_W-1:0]   rd_capture_s;

    // Grant decision and winner command mux, evaluated while idle.
    always_comb begin
        sel_s = GNT_DMA;
        if (cpu_req && dma_req) begin
            if (FIXED_PRIO != 0) begin
                sel_s = GNT_CPU;
            end else if (last_q == GNT_DMA) begin
                sel_s = GNT_CPU;
            end else begin
                sel_s = GNT_DMA;
            end
        end else if (cpu_req) begin
            sel_s = GNT_CPU;
        end else begin
            sel_s = GNT_DMA;
        end
        sel_we_s    = (sel_s == GNT_CPU) ? cpu_we    : dma_we;
        sel_addr_s  = (sel_s == GNT_CPU) ? cpu_addr  : dma_addr;
        sel_wdata_s = (sel_s == GNT_CPU) ? cpu_wdata : dma_wdata;
`ifdef DATA_MEM_ARB_ADDR_CHECK_EN
        sel_bad_s = addr_out_of_range(sel_addr_s);
`else
        sel_bad_s = 1'b0;
`endif
    end

    // Next-state and registered-output logic; memory strobes are 0 unless entering ACCESS.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        win_d        = win_q;
        we_d         = we_q;
        bad_d        = bad_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        cpu_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        cpu_err_d    = 1'b0;
        dma_err_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        rd_capture_s = (we_q || bad_q) ? '0 : mem_rdata;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d     = ST_ACCESS;
                    last_d      = sel_s;
                    win_d       = sel_s;
                    we_d        = sel_we_s;
                    bad_d       = sel_bad_s;
                    mem_read_d  = ~sel_we_s & ~sel_bad_s;
                    mem_write_d = sel_we_s & ~sel_bad_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (win_q == GNT_CPU) begin
                    cpu_ack_d   = 1'b1;
                    cpu_err_d   = bad_q;
                    cpu_rdata_d = rd_capture_s;
                end else begin
                    dma_ack_d   = 1'b1;
                    dma_err_d   = bad_q;
                    dma_rdata_d = rd_capture_s;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= GNT_DMA;
            win_q       <= GNT_CPU;
            we_q        <= 1'b0;
            bad_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            we_q        <= we_d;
            bad_q       <= bad_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_err_q   <= cpu_err_d;
            dma_err_q   <= dma_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_err   = cpu_err_q;
    assign dma_err   = dma_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: round-robin instance with a RAM model,
// plus a fixed-priority instance reading from a constant pattern.
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00, dma_addr = 8'h00, dma_wdata = 8'h00;
    logic       cpu_ack, cpu_err, dma_ack, dma_err, mem_read, mem_write, busy;
    logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

    logic       c1_req = 1'b0, d1_req = 1'b0;
    logic [7:0] c1_addr = 8'h00, d1_addr = 8'h00;
    logic       c1_ack, c1_err, d1_ack, d1_err, m1_read, m1_write, busy1;
    logic [7:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;

    logic [7:0] mem [8];
    int cyc = 0, n_tests = 0, n_fail = 0, mw_cnt = 0, mr_cnt = 0;
    logic [7:0] last_cpu = 8'h00, last_dma = 8'h00;

    typedef struct { bit is_cpu; bit we; logic [7:0] addr; logic [7:0] wdata; logic [7:0] exp_rd; } vec_t;
    typedef struct { bit is_cpu; logic [7:0] rd; bit err; int due; } exp_t;
    vec_t vecs[10];
    exp_t sb[$];

    data_mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_AW(3), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

    data_mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_AW(3), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(8'h00),
        .cpu_ack(c1_ack), .cpu_rdata(c1_rdata), .cpu_err(c1_err),
        .dma_req(d1_req), .dma_we(1'b0), .dma_addr(d1_addr), .dma_wdata(8'h00),
        .dma_ack(d1_ack), .dma_rdata(d1_rdata), .dma_err(d1_err),
        .mem_read(m1_read), .mem_write(m1_write), .mem_addr(m1_addr),
        .mem_wdata(m1_wdata), .mem_rdata(m1_rdata), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on posedge; second instance reads a fixed pattern.
    assign mem_rdata = mem[mem_addr[2:0]];
    assign m1_rdata  = 8'h50 | {5'd0, m1_addr[2:0]};
    always @(posedge clk) if (mem_write) mem[mem_addr[2:0]] <= mem_wdata;

    always @(negedge clk) begin
        if (mem_write) mw_cnt <= mw_cnt + 1;
        if (mem_read)  mr_cnt <= mr_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && (cpu_ack || dma_ack)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_who", {30'd0, cpu_ack, dma_ack}, e.is_cpu ? 32'd2 : 32'd1);
                chk("ack_rdata", e.is_cpu ? cpu_rdata : dma_rdata, e.rd);
                chk("ack_err", e.is_cpu ? cpu_err : dma_err, e.err);
                chk("ack_cycle", cyc, e.due);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_cpu = 8'h00; last_dma = 8'h00;
    endtask

    task automatic access(input bit is_cpu, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd, input bit exp_err);
        int mw0, mr0;
        bit got;
        @(negedge clk);
        if (is_cpu) begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        else        begin dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
        sb.push_back('{is_cpu, exp_rd, exp_err, cyc + 2});
        mw0 = mw_cnt; mr0 = mr_cnt; got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (is_cpu ? cpu_ack : dma_ack) begin
                got = 1'b1;
                cpu_req = 1'b0; dma_req = 1'b0;
            end
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        if (!got) begin
            cpu_req = 1'b0; dma_req = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        chk("mem_write_pulses", mw_cnt - mw0, (we && !exp_err) ? 32'd1 : 32'd0);
        chk("mem_read_pulses", mr_cnt - mr0, (!we && !exp_err) ? 32'd1 : 32'd0);
        chk("loser_rdata_hold", is_cpu ? dma_rdata : cpu_rdata, is_cpu ? last_dma : last_cpu);
        if (is_cpu) last_cpu = exp_rd; else last_dma = exp_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, nc, nd, n;
        vecs[0] = '{1'b1, 1'b1, 8'h03, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h03, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 8'h07, 8'h3C, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 8'h07, 8'h00, 8'h3C};
        vecs[4] = '{1'b0, 1'b1, 8'h01, 8'h41, 8'h00};
        vecs[5] = '{1'b1, 1'b1, 8'h02, 8'h42, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 8'h02, 8'h00, 8'h42};
        vecs[7] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h41};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h22, 8'h00};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h22};

        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
        chk("rst_errs", {30'd0, cpu_err, dma_err}, 32'd0);
        chk("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_buses", {16'd0, mem_addr, mem_wdata}, 32'd0);
        chk("rst_rdata", {16'd0, cpu_rdata, dma_rdata}, 32'd0);

        // Fixed priority: CPU served on every tie, DMA only once CPU drops its request.
        @(negedge clk);
        c1_req = 1'b1; c1_addr = 8'h01; d1_req = 1'b1; d1_addr = 8'h02;
        t0 = cyc; n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            if (c1_ack || d1_ack) begin
                n++;
                chk("fp_who", {30'd0, c1_ack, d1_ack}, (n <= 3) ? 32'd2 : 32'd1);
                chk("fp_cycle", cyc - t0, 3 * n - 1);
                chk("fp_rdata", c1_ack ? c1_rdata : d1_rdata, c1_ack ? 32'h51 : 32'h52);
                if (n == 3) c1_req = 1'b0;
                if (n == 4) d1_req = 1'b0;
            end
        end
        c1_req = 1'b0; d1_req = 1'b0;
        chk("fp_ack_count", n, 32'd4);

        for (int i = 0; i < 10; i++)
            access(vecs[i].is_cpu, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0);

        // Reset during ACCESS of a CPU read: no ack, everything idle next cycle.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h03;
        @(negedge clk);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        chk("midrst_mem_read_before", {31'd0, mem_read}, 32'd1);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
        chk("midrst_mem", {14'd0, mem_read, mem_write, mem_addr, mem_wdata}, 32'd0);
        chk("midrst_rdata", {24'd0, cpu_rdata}, 32'd0);
        rst = 1'b0; last_cpu = 8'h00; last_dma = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_late_ack", {31'd0, cpu_ack}, 32'd0);
        end

        // Round-robin tie after reset: CPU, DMA, CPU, DMA, acks three cycles apart.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h02;
        t0 = cyc;
        sb.push_back('{1'b1, 8'h41, 1'b0, t0 + 2});
        sb.push_back('{1'b0, 8'h42, 1'b0, t0 + 5});
        sb.push_back('{1'b1, 8'h41, 1'b0, t0 + 8});
        sb.push_back('{1'b0, 8'h42, 1'b0, t0 + 11});
        nc = 0; nd = 0;
        for (int i = 0; i < 20 && (nc < 2 || nd < 2); i++) begin
            @(negedge clk);
            if (cpu_ack) begin nc++; if (nc == 2) cpu_req = 1'b0; end
            if (dma_ack) begin nd++; if (nd == 2) dma_req = 1'b0; end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("rr_cpu_acks", nc, 32'd2);
        chk("rr_dma_acks", nd, 32'd2);
        last_cpu = 8'h41; last_dma = 8'h42;

`ifdef DATA_MEM_ARB_ADDR_CHECK_EN
        access(1'b1, 1'b1, 8'h0B, 8'hFF, 8'h00, 1'b1);
        access(1'b1, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0);
        access(1'b0, 1'b0, 8'h0B, 8'h00, 8'h00, 1'b1);
`else
        access(1'b1, 1'b1, 8'h0B, 8'hFF, 8'h00, 1'b0);
        access(1'b1, 1'b0, 8'h03, 8'h00, 8'hFF, 1'b0);
        access(1'b0, 1'b0, 8'h8B, 8'h00, 8'hFF, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
